// File: rtl/cordic_pkg.sv
// Shared CORDIC constants (Q3.29 master copies, rounded per instance) and stage tag bundle.
package cordic_pkg;

  localparam int TAB_FRAC = 29;

  localparam logic signed [31:0] ATAN_TAB [16] = '{
    32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
    32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
    32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
    32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384
  };

  localparam logic signed [31:0] CORDIC_K   = 32'sd326016437;
  localparam logic signed [31:0] PI_Q3      = 32'sd1686629713;
  localparam logic signed [31:0] HALF_PI_Q3 = 32'sd843314857;

  // Control bits that ride alongside each sample; x/y/z widths depend on the
  // instance parameters, so they travel as separate packed arrays.
  typedef struct packed {
    logic valid;
    logic mode;
    logic flip;
  } stage_tag_t;

  // Round a Q3.29 constant to frac_bits fractional bits (half-up).
  function automatic logic signed [31:0] q_round(input logic signed [31:0] v, input int frac_bits);
    if (frac_bits >= TAB_FRAC) return v <<< (frac_bits - TAB_FRAC);
    return (v + (32'sd1 <<< (TAB_FRAC - frac_bits - 1))) >>> (TAB_FRAC - frac_bits);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation. Vectoring direction select only with CORDIC_VECTORING_EN.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int                    XW    = 13,
  parameter int                    IW    = 11,
  parameter int                    SHIFT = 0,
  parameter logic signed [IW-1:0]  ATAN  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  stage_tag_t           in_tag,
  input  logic signed [XW-1:0] in_x,
  input  logic signed [XW-1:0] in_y,
  input  logic signed [IW-1:0] in_z,
  output stage_tag_t           out_tag,
  output logic signed [XW-1:0] out_x,
  output logic signed [XW-1:0] out_y,
  output logic signed [IW-1:0] out_z
);

  // neg = 1 selects d = -1 (rotate clockwise, add the angle back to z)
  logic neg;

  always_comb begin
`ifdef CORDIC_VECTORING_EN
    neg = in_tag.mode ? !in_y[XW-1] : in_z[IW-1];
`else
    neg = in_z[IW-1];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tag <= '0;
      out_x   <= '0;
      out_y   <= '0;
      out_z   <= '0;
    end else begin
      out_tag <= in_tag;
      if (in_tag.valid) begin
        if (neg) begin
          out_x <= in_x + (in_y >>> SHIFT);
          out_y <= in_y - (in_x >>> SHIFT);
          out_z <= in_z + ATAN;
        end else begin
          out_x <= in_x - (in_y >>> SHIFT);
          out_y <= in_y + (in_x >>> SHIFT);
          out_z <= in_z - ATAN;
        end
      end
    end
  end

endmodule

// File: rtl/cordic_param_pipe.sv
// Fully pipelined CORDIC, latency STAGES+2. Define CORDIC_VECTORING_EN for per-sample vectoring mode.
module cordic_param_pipe
  import cordic_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = W,
  parameter int GUARD  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_mode,
  input  logic [W-1:0] in_angle,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         out_valid,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_angle
);

  localparam int IW = W + GUARD;
  // x/y carry two extra integer bits (Q3.(IW-1)) so the vectoring gain never wraps
  localparam int XW = IW + 2;
  localparam int XF = IW - 1;
  localparam int ZF = IW - 3;

  localparam logic signed [IW-1:0] PI_Z      = IW'(q_round(PI_Q3, ZF));
  localparam logic signed [IW-1:0] HALF_PI_Z = IW'(q_round(HALF_PI_Q3, ZF));
  localparam logic signed [XW-1:0] K_X       = XW'(q_round(CORDIC_K, XF));
  localparam logic signed [XW:0]   SAT_MAX   = (XW+1)'(2**(W-1) - 1);

  function automatic logic [W-1:0] rnd_sat(input logic signed [XW-1:0] v, input int sh);
    logic signed [XW:0] t;
    t = ($signed({v[XW-1], v}) + $signed((XW+1)'(1) << (sh - 1))) >>> sh;
    if (t > SAT_MAX)  return SAT_MAX[W-1:0];
    if (t < -SAT_MAX) return W'(-SAT_MAX);
    return t[W-1:0];
  endfunction

  stage_tag_t [STAGES:0]          tag_pipe;
  logic       [STAGES:0][XW-1:0]  x_pipe;
  logic       [STAGES:0][XW-1:0]  y_pipe;
  logic       [STAGES:0][IW-1:0]  z_pipe;

  logic signed [IW-1:0] ang_q;
  logic signed [XW-1:0] x0, y0;
  logic signed [IW-1:0] z0;
  logic                 flip0, mode0;

  stage_tag_t           s0_tag;
  logic signed [XW-1:0] s0_x, s0_y;
  logic signed [IW-1:0] s0_z;

  assign ang_q = $signed({in_angle, {GUARD{1'b0}}});

`ifdef CORDIC_VECTORING_EN
  logic signed [XW-1:0] xv, yv;
  assign xv = $signed({{(XW-IW){in_x[W-1]}}, in_x, {GUARD{1'b0}}});
  assign yv = $signed({{(XW-IW){in_y[W-1]}}, in_y, {GUARD{1'b0}}});
`else
  logic unused_in;
  assign unused_in = ^{in_mode, in_x, in_y};
`endif

  // Fold the angle into [-pi/2, pi/2]; the half-turn is undone by negating at the output.
  always_comb begin
    mode0 = 1'b0;
    flip0 = 1'b0;
    x0    = K_X;
    y0    = '0;
    z0    = ang_q;
    if (ang_q > HALF_PI_Z) begin
      z0    = ang_q - PI_Z;
      flip0 = 1'b1;
    end else if (ang_q < -HALF_PI_Z) begin
      z0    = ang_q + PI_Z;
      flip0 = 1'b1;
    end
`ifdef CORDIC_VECTORING_EN
    if (in_mode) begin
      mode0 = 1'b1;
      flip0 = 1'b0;
      x0    = xv;
      y0    = yv;
      z0    = '0;
      if (xv < 0) begin
        x0 = -xv;
        y0 = -yv;
        z0 = (yv < 0) ? -PI_Z : PI_Z;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_tag <= '0;
      s0_x   <= '0;
      s0_y   <= '0;
      s0_z   <= '0;
    end else begin
      s0_tag <= '{valid: in_valid, mode: mode0, flip: flip0};
      if (in_valid) begin
        s0_x <= x0;
        s0_y <= y0;
        s0_z <= z0;
      end
    end
  end

  assign tag_pipe[0] = s0_tag;
  assign x_pipe[0]   = s0_x;
  assign y_pipe[0]   = s0_y;
  assign z_pipe[0]   = s0_z;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam logic signed [IW-1:0] ATAN_I = IW'(q_round(ATAN_TAB[i], ZF));
    cordic_stage #(.XW(XW), .IW(IW), .SHIFT(i), .ATAN(ATAN_I)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .in_tag  (tag_pipe[i]),
      .in_x    (x_pipe[i]),
      .in_y    (y_pipe[i]),
      .in_z    (z_pipe[i]),
      .out_tag (tag_pipe[i+1]),
      .out_x   (x_pipe[i+1]),
      .out_y   (y_pipe[i+1]),
      .out_z   (z_pipe[i+1])
    );
  end

  stage_tag_t           tag_l;
  logic signed [XW-1:0] x_l, y_l, x_f, y_f;

  assign tag_l = tag_pipe[STAGES];
  assign x_l   = $signed(x_pipe[STAGES]);
  assign y_l   = $signed(y_pipe[STAGES]);
  assign x_f   = tag_l.flip ? -x_l : x_l;
  assign y_f   = tag_l.flip ? -y_l : y_l;

`ifdef CORDIC_VECTORING_EN
  logic signed [XW-1:0] z_ext;
  assign z_ext = $signed({{(XW-IW){z_pipe[STAGES][IW-1]}}, z_pipe[STAGES]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_angle <= '0;
    end else begin
      out_valid <= tag_l.valid;
      if (tag_l.valid) begin
        // magnitude leaves in Q3, so it drops two more bits than a Q1 result
        out_x     <= rnd_sat(x_f, tag_l.mode ? GUARD + 2 : GUARD);
        out_y     <= rnd_sat(y_f, GUARD);
        out_angle <= tag_l.mode ? rnd_sat(z_ext, GUARD) : '0;
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^{tag_l.mode, z_pipe[STAGES]};
  assign out_angle   = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= tag_l.valid;
      if (tag_l.valid) begin
        out_x <= rnd_sat(x_f, GUARD);
        out_y <= rnd_sat(y_f, GUARD);
      end
    end
  end
`endif

endmodule
